// File: rtl/show_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | show_uart_tx: sends up to MAX_BYTES buffered bytes as back-to-back 8N1      |
// | frames. Define SHOW_UART_CRLF_EN to append 0x0D,0x0A after the payload.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module show_uart_tx #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 115200,
  parameter int MAX_BYTES = 16
) (
  input  logic                   CLK100MHZ,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*MAX_BYTES-1:0] show_buf,
  input  logic [4:0]             show_len,
  output logic                   busy,
  output logic                   done,
  output logic                   tx_pin_out
);

  localparam int DIV    = CLK_FREQ / BAUD;
  localparam int BAUD_W = $clog2(DIV);
`ifdef SHOW_UART_CRLF_EN
  localparam int EXTRA  = 2;
`else
  localparam int EXTRA  = 0;
`endif
  localparam int IDX_W  = $clog2(MAX_BYTES + EXTRA + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       len_q, len_d;
  logic [8*MAX_BYTES-1:0] buf_q, buf_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   tx_q, tx_d;

  logic [IDX_W-1:0]       len_clamped;
  logic [IDX_W-1:0]       total_frames;
  logic                   baud_end;
  logic [7:0]             sel_byte;

  always_comb begin
    len_clamped  = IDX_W'(show_len);
    if (int'(show_len) > MAX_BYTES) len_clamped = IDX_W'(MAX_BYTES);
    total_frames = len_q + IDX_W'(EXTRA);
    baud_end     = (baud_q == BAUD_W'(DIV - 1));

    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    len_d   = len_q;
    buf_d   = buf_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          buf_d  = show_buf;
          len_d  = len_clamped;
          idx_d  = '0;
          bit_d  = '0;
          baud_d = '0;
          if (len_clamped != '0) state_d = S_START;
          else                   done_d  = 1'b1;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // The next start bit follows immediately so frames stay back-to-back.
          if (idx_q + IDX_W'(1) == total_frames) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_START;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    sel_byte = 8'hFF;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (idx_d == IDX_W'(i)) sel_byte = buf_d[8*i +: 8];
    end
`ifdef SHOW_UART_CRLF_EN
    if (idx_d == len_d)                    sel_byte = 8'h0D;
    else if (idx_d == len_d + IDX_W'(1))   sel_byte = 8'h0A;
`endif

    // Line level is derived from next state so the pin comes straight off a flop.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = sel_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      buf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign tx_pin_out = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_show_uart_tx.sv
`default_nettype none
// Testbench for show_uart_tx: random messages compared against a per-cycle line model.
module tb_show_uart_tx;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int MAXB     = 16;

  logic         CLK100MHZ = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] show_buf = '0;
  logic [4:0]   show_len = '0;
  logic         busy, done, tx_pin_out;

  int checks = 0;
  int passed = 0;
  logic exp_q[$];

  show_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MAX_BYTES(MAXB)) dut (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .start     (start),
    .show_buf  (show_buf),
    .show_len  (show_len),
    .busy      (busy),
    .done      (done),
    .tx_pin_out(tx_pin_out)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  function automatic logic [127:0] rand_buf();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Expected line level for every cycle of the message, starting the cycle after start.
  task automatic build_model(input logic [127:0] b, input logic [4:0] l);
    int n;
    logic [7:0] bytes[$];
    exp_q.delete();
    n = (int'(l) > MAXB) ? MAXB : int'(l);
    for (int i = 0; i < n; i++) bytes.push_back(b[8*i +: 8]);
`ifdef SHOW_UART_CRLF_EN
    if (n > 0) begin
      bytes.push_back(8'h0D);
      bytes.push_back(8'h0A);
    end
`endif
    foreach (bytes[i]) begin
      for (int c = 0; c < DIV; c++) exp_q.push_back(1'b0);
      for (int k = 0; k < 8; k++)
        for (int c = 0; c < DIV; c++) exp_q.push_back(bytes[i][k]);
      for (int c = 0; c < DIV; c++) exp_q.push_back(1'b1);
    end
  endtask

  task automatic run_msg(input string name, input logic [127:0] b, input logic [4:0] l,
                         input bit interfere);
    int bad_tx, bad_busy, bad_done, first_bad;
    bad_tx = 0; bad_busy = 0; bad_done = 0; first_bad = -1;
    build_model(b, l);
    show_buf = b;
    show_len = l;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      if (interfere && c == 40) begin
        show_buf = rand_buf();
        show_len = 5'd7;
        start    = 1'b1;
      end
      if (interfere && c == 41) start = 1'b0;
      if (tx_pin_out !== exp_q[c]) begin
        bad_tx++;
        if (first_bad < 0) first_bad = c;
      end
      if (busy !== 1'b1) bad_busy++;
      if (done !== 1'b0) bad_done++;
      tick();
    end
    checks++;
    if (bad_tx != 0)
      $display("FAIL %s tx_wave: %0d wrong cycles (first at %0d), required 0", name, bad_tx, first_bad);
    else passed++;
    checks++;
    if (bad_busy != 0) $display("FAIL %s busy_high: %0d low cycles, required 0", name, bad_busy);
    else passed++;
    checks++;
    if (bad_done != 0) $display("FAIL %s early_done: %0d done cycles, required 0", name, bad_done);
    else passed++;
    checks++;
    if ({done, busy, tx_pin_out} !== 3'b101)
      $display("FAIL %s end: done/busy/tx=%b, required 101", name, {done, busy, tx_pin_out});
    else passed++;
    tick();
    checks++;
    if ({done, busy, tx_pin_out} !== 3'b001)
      $display("FAIL %s after_end: done/busy/tx=%b, required 001", name, {done, busy, tx_pin_out});
    else passed++;
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    checks++;
    if ({done, busy, tx_pin_out} !== 3'b001)
      $display("FAIL reset_state: done/busy/tx=%b, required 001", {done, busy, tx_pin_out});
    else passed++;
    reset = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if ({done, busy, tx_pin_out} !== 3'b001) bad++;
      tick();
    end
    checks++;
    if (bad != 0) $display("FAIL idle_after_reset: %0d bad cycles, required 0", bad);
    else passed++;
  endtask

  task automatic test_single_a5();
    logic [127:0] b;
    b = rand_buf();
    b[7:0] = 8'hA5;
    run_msg("a5", b, 5'd1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [127:0] b;
    b = rand_buf();
    b[23:0] = 24'h333231;
    run_msg("str123", b, 5'd3, 1'b0);
    for (int r = 0; r < 3; r++)
      run_msg("random", rand_buf(), 5'($urandom_range(1, 4)), 1'b0);
  endtask

  task automatic test_ignore_start();
    run_msg("ignore_start", rand_buf(), 5'd2, 1'b1);
  endtask

  task automatic test_len_edges();
    run_msg("len0", rand_buf(), 5'd0, 1'b0);
    run_msg("clamp20", rand_buf(), 5'd20, 1'b0);
  endtask

  task automatic test_mid_reset();
    int bad;
    bad = 0;
    show_buf = rand_buf();
    show_len = 5'd2;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    repeat (10*DIV + 3*DIV + 4) tick();
    checks++;
    if (busy !== 1'b1) $display("FAIL mid_busy: busy=%b, required 1", busy);
    else passed++;
    reset = 1'b1;
    tick();
    checks++;
    if ({done, busy, tx_pin_out} !== 3'b001)
      $display("FAIL mid_reset: done/busy/tx=%b, required 001", {done, busy, tx_pin_out});
    else passed++;
    reset = 1'b0;
    for (int c = 0; c < 25*DIV; c++) begin
      if ({done, busy, tx_pin_out} !== 3'b001) bad++;
      tick();
    end
    checks++;
    if (bad != 0) $display("FAIL post_reset_quiet: %0d bad cycles, required 0", bad);
    else passed++;
    run_msg("after_reset", rand_buf(), 5'd1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_ignore_start();
    test_len_edges();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
